bcd_press_display: RTL

BCD_PRESS_DISPLAY -- requirements
Module: bcd_press_display

---
 rtl/bcd_press_display_pkg.sv | 23 ++
 rtl/bcd_press_display_seg.sv | 27 ++
 rtl/bcd_press_display.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bcd_press_display_pkg.sv
// Shared types and constants for the two-digit BCD press counter display.
// Segment patterns are active-low, bit0 = A through bit6 = G.
package bcd_press_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } blink_state_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_press_display_seg.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes 10-15 cannot occur upstream; they decode to blank as a safe default.
module bcd_to_seven_seg
    import bcd_press_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_press_display.sv
// Two-digit BCD press counter with registered seven-segment outputs and a
// blink sequence after every 99->00 wrap.
//
// state    | meaning
// ---------|--------------------------------------------------------------
// ST_IDLE  | digits shown, waiting for a wrap
// ST_BLANK | both digits blanked for one blink phase
// ST_SHOW  | live digits shown for one blink phase, then next flash or idle
module bcd_press_display
    import bcd_press_display_pkg::*;
#(
    parameter int C_BLINK_COUNT   = 6250000,
    parameter int C_BLINK_FLASHES = 3
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_inc,
    input  logic       i_clr,
    output logic [6:0] o_seg_tens,
    output logic [6:0] o_seg_ones,
    output logic       o_wrap
);

    localparam int PHASE_W = $clog2(C_BLINK_COUNT);
    localparam int FLASH_W = $clog2(C_BLINK_FLASHES + 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST   = PHASE_W'(C_BLINK_COUNT - 1);
    localparam logic [FLASH_W-1:0] FLASH_TARGET = FLASH_W'(C_BLINK_FLASHES);

    logic               r_inc_d;
    logic [3:0]         r_ones;
    logic [3:0]         r_tens;
    logic               r_wrap;
    blink_state_t       r_state, state_nxt;
    logic [PHASE_W-1:0] r_phase, phase_nxt;
    logic [FLASH_W-1:0] r_flash, flash_nxt;
    logic [FLASH_W-1:0] flash_inc;
    logic [6:0]         seg_tens_dec;
    logic [6:0]         seg_ones_dec;
    logic               rise;
    logic               count_en;
    logic               ones_carry;
    logic               wrap_evt;

    assign rise       = i_inc & ~r_inc_d;
    assign count_en   = rise & ~i_clr;
    assign ones_carry = (r_ones == 4'd9);
    assign wrap_evt   = count_en & ones_carry & (r_tens == 4'd9);
    assign flash_inc  = r_flash + FLASH_W'(1);

    // r_inc_d resets high so a switch already closed at release is not a press
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inc_d <= 1'b1;
            r_ones  <= 4'd0;
            r_tens  <= 4'd0;
            r_wrap  <= 1'b0;
        end else begin
            r_inc_d <= i_inc;
            r_wrap  <= wrap_evt;
            if (i_clr) begin
                r_ones <= 4'd0;
                r_tens <= 4'd0;
            end else if (count_en) begin
                if (ones_carry) begin
                    r_ones <= 4'd0;
                    r_tens <= (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
                end else begin
                    r_ones <= r_ones + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
            r_flash <= '0;
        end else begin
            r_state <= state_nxt;
            r_phase <= phase_nxt;
            r_flash <= flash_nxt;
        end
    end

    // The registered wrap pulse launches the blink so the 00 frame shows first
    always_comb begin
        state_nxt = r_state;
        phase_nxt = r_phase;
        flash_nxt = r_flash;
        if (i_clr) begin
            state_nxt = ST_IDLE;
            phase_nxt = '0;
            flash_nxt = '0;
        end else if (r_wrap) begin
            state_nxt = ST_BLANK;
            phase_nxt = '0;
            flash_nxt = '0;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    if (r_phase == PHASE_LAST) begin
                        phase_nxt = '0;
                        state_nxt = ST_SHOW;
                    end else begin
                        phase_nxt = r_phase + PHASE_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (r_phase == PHASE_LAST) begin
                        phase_nxt = '0;
                        if (flash_inc < FLASH_TARGET) begin
                            flash_nxt = flash_inc;
                            state_nxt = ST_BLANK;
                        end else begin
                            flash_nxt = '0;
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        phase_nxt = r_phase + PHASE_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    phase_nxt = '0;
                    flash_nxt = '0;
                end
            endcase
        end
    end

    bcd_to_seven_seg u_seg_tens (
        .bcd (r_tens),
        .seg (seg_tens_dec)
    );

    bcd_to_seven_seg u_seg_ones (
        .bcd (r_ones),
        .seg (seg_ones_dec)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_seg_tens <= SEG_0;
            o_seg_ones <= SEG_0;
        end else if (r_state == ST_BLANK) begin
            o_seg_tens <= SEG_BLANK;
            o_seg_ones <= SEG_BLANK;
        end else begin
            o_seg_tens <= seg_tens_dec;
            o_seg_ones <= seg_ones_dec;
        end
    end

    assign o_wrap = r_wrap;

endmodule
